// File: rtl/hall_decoder.sv
// Purpose: Hall sensor decoder: synchronize, debounce, map to sector, infer direction, measure edge period, flag faults/stall.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from the first clk edge sampling a new hall_in to hall_edge.
// Backpressure: none; free-running sampled input, outputs are registered levels plus a one-clock hall_edge pulse.
//
// Ports:
//   clk, reset_n (async, active low)  | hall_in[2:0] raw {A,B,C} | clear_fault single-cycle sticky-fault clear
//   sector[2:0] (7 = invalid/unknown) | direction (0 fwd, 1 rev) | hall_edge accept pulse
//   period / period_valid             | stalled                  | hall_fault (sticky)
module hall_decoder #(
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          PERIOD_WIDTH    = 32,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              hall_in,
    input  logic                    clear_fault,
    output logic [2:0]              sector,
    output logic                    direction,
    output logic                    hall_edge,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stalled,
    output logic                    hall_fault
);

    localparam logic [15:0]             DEB_CNT   = 16'(DEBOUNCE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_P = PERIOD_WIDTH'(TIMEOUT_CYCLES);

    function automatic logic [2:0] code_to_sector(input logic [2:0] code);
        case (code)
            3'b011:  return 3'd0;
            3'b010:  return 3'd1;
            3'b110:  return 3'd2;
            3'b100:  return 3'd3;
            3'b101:  return 3'd4;
            3'b001:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  last_q;     // synchronizer output one clock ago
    logic [2:0]                  acc_q,      acc_d;
    logic [15:0]                 cnt_q,      cnt_d;
    logic [PERIOD_WIDTH-1:0]     timer_q,    timer_d;
    logic [2:0]                  sector_q,   sector_d;
    logic                        dir_q,      dir_d;
    logic                        edge_q,     edge_d;
    logic [PERIOD_WIDTH-1:0]     period_q,   period_d;
    logic                        pv_q,       pv_d;
    logic                        stalled_q,  stalled_d;
    logic                        fault_q,    fault_d;
    // A legal step has been accepted since the last reset/fault/resync/stall,
    // so dir_q is a valid reference for the next step.
    logic                        have_prev_q, have_prev_d;

    logic [2:0]              sync_cur;
    logic [2:0]              n_sec;
    logic [2:0]              fwd_sec;
    logic [2:0]              rev_sec;
    logic [15:0]             cnt_next;
    logic [PERIOD_WIDTH-1:0] timer_inc;
    logic                    accept;
    logic                    fault_evt;
    logic                    step_dir;

    assign sync_cur  = sync_q[SYNC_STAGES-1];
    assign n_sec     = code_to_sector(sync_cur);
    assign fwd_sec   = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    assign rev_sec   = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    // The clock on which a new value first appears counts as stable clock 1.
    assign cnt_next  = (sync_cur != last_q) ? 16'd1 : cnt_q + 16'd1;
    assign accept    = (sync_cur != acc_q) && (cnt_next == DEB_CNT);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = '0;
        timer_d     = timer_inc;
        sector_d    = sector_q;
        dir_d       = dir_q;
        edge_d      = 1'b0;
        period_d    = period_q;
        pv_d        = pv_q;
        stalled_d   = stalled_q;
        have_prev_d = have_prev_q;
        fault_evt   = 1'b0;
        step_dir    = 1'b0;

        if (sync_cur != acc_q && !accept) begin
            cnt_d = cnt_next;
        end

        if (accept) begin
            acc_d     = sync_cur;
            sector_d  = n_sec;
            edge_d    = 1'b1;
            period_d  = timer_inc;
            timer_d   = '0;
            stalled_d = 1'b0;
            if (n_sec == 3'd7) begin
                fault_evt   = 1'b1;
                pv_d        = 1'b0;
                have_prev_d = 1'b0;
            end else if (sector_q == 3'd7) begin
                // Resync from unknown position: no direction information yet.
                pv_d        = 1'b0;
                have_prev_d = 1'b0;
            end else if (n_sec == fwd_sec || n_sec == rev_sec) begin
                step_dir    = (n_sec == rev_sec);
                pv_d        = have_prev_q && (step_dir == dir_q);
                dir_d       = step_dir;
                have_prev_d = 1'b1;
            end else begin
                fault_evt   = 1'b1;
                pv_d        = 1'b0;
                have_prev_d = 1'b0;
            end
        end else if (timer_inc >= TIMEOUT_P) begin
            stalled_d   = 1'b1;
            pv_d        = 1'b0;
            have_prev_d = 1'b0;
        end

        // A new fault in the clearing cycle keeps the flag set.
        fault_d = (fault_q & ~clear_fault) | fault_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            last_q      <= 3'b000;
            acc_q       <= 3'b000;
            cnt_q       <= '0;
            timer_q     <= '0;
            sector_q    <= 3'd7;
            dir_q       <= 1'b0;
            edge_q      <= 1'b0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            stalled_q   <= 1'b0;
            fault_q     <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], hall_in};
            last_q      <= sync_cur;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            sector_q    <= sector_d;
            dir_q       <= dir_d;
            edge_q      <= edge_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            stalled_q   <= stalled_d;
            fault_q     <= fault_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign sector       = sector_q;
    assign direction    = dir_q;
    assign hall_edge    = edge_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stalled      = stalled_q;
    assign hall_fault   = fault_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Purpose: self-checking bench for hall_decoder; expected edge results queued at stimulus time, popped on hall_edge.
// Latency: expects hall_edge 6 clocks after each hall_in change (2 sync + 4 debounce).
// Backpressure: none.
module tb_hall_decoder;

    localparam int LAT  = 6;
    localparam int HOLD = 100;

    typedef struct {
        logic [2:0]  sec;
        logic        dir;
        logic        pv;
        logic        stl;
        logic        flt;
        logic [31:0] per;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  hall_in;
    logic        clear_fault;
    logic [2:0]  sector;
    logic        direction;
    logic        hall_edge;
    logic [31:0] period;
    logic        period_valid;
    logic        stalled;
    logic        hall_fault;

    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   last_edge = 0;
    exp_t sb[$];

    hall_decoder #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .PERIOD_WIDTH   (32),
        .TIMEOUT_CYCLES (32'd1000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hall_in     (hall_in),
        .clear_fault (clear_fault),
        .sector      (sector),
        .direction   (direction),
        .hall_edge   (hall_edge),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled),
        .hall_fault  (hall_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_sector"},  32'(sector),       32'd7);
        chk({pfx, "_dir"},     32'(direction),    32'd0);
        chk({pfx, "_edge"},    32'(hall_edge),    32'd0);
        chk({pfx, "_period"},  period,            32'd0);
        chk({pfx, "_pv"},      32'(period_valid), 32'd0);
        chk({pfx, "_stalled"}, 32'(stalled),      32'd0);
        chk({pfx, "_fault"},   32'(hall_fault),   32'd0);
    endtask

    // Queue the result expected LAT clocks after the current cycle.
    task automatic push_exp(input logic [2:0] s, input logic d, input logic pv, input logic f);
        exp_t e;
        e.cyc     = cyc + LAT;
        e.per     = 32'(e.cyc - last_edge);
        last_edge = e.cyc;
        e.sec     = s;
        e.dir     = d;
        e.pv      = pv;
        e.stl     = 1'b0;
        e.flt     = f;
        sb.push_back(e);
    endtask

    // Called #1 after a posedge; drives a code and holds it HOLD clocks.
    // clr raises clear_fault exactly on the clock that accepts this code.
    task automatic step(input logic [2:0] code, input logic [2:0] s, input logic d,
                        input logic pv, input logic f, input bit clr);
        hall_in = code;
        push_exp(s, d, pv, f);
        if (clr) begin
            repeat (LAT - 1) @(posedge clk);
            #1 clear_fault = 1'b1;
            @(posedge clk);
            #1 clear_fault = 1'b0;
            repeat (HOLD - LAT) @(posedge clk);
        end else begin
            repeat (HOLD) @(posedge clk);
        end
        #1;
    endtask

    task automatic pulse_clear(input string tag);
        clear_fault = 1'b1;
        @(posedge clk);
        #1 clear_fault = 1'b0;
        chk(tag, 32'(hall_fault), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && hall_edge !== 1'b0) begin
            tests++;
            assert (sb.size() > 0)
            else begin
                fails++;
                $error("FAIL unexpected_edge observed sector=%0d at cycle %0d, expected no edge", sector, cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("edge_cycle",   32'(cyc),          32'(e.cyc));
                chk("edge_sector",  32'(sector),       32'(e.sec));
                chk("edge_dir",     32'(direction),    32'(e.dir));
                chk("edge_period",  period,            e.per);
                chk("edge_pv",      32'(period_valid), 32'(e.pv));
                chk("edge_stalled", 32'(stalled),      32'(e.stl));
                chk("edge_fault",   32'(hall_fault),   32'(e.flt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        hall_in     = 3'b000;
        clear_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n   = 1'b1;
        last_edge = cyc;
        repeat (5) @(posedge clk);
        #1;

        // Forward rotation: resync, then two forward steps before period_valid.
        step(3'b011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'b010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'b110, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b100, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b101, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b001, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b010, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b110, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'b100, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reversal at sector 3.
        step(3'b110, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'b010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'b011, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // 3-clock glitch must not be accepted.
        hall_in = 3'b010;
        repeat (3) @(posedge clk);
        #1 hall_in = 3'b011;
        repeat (97) @(posedge clk);
        #1;
        chk("glitch_sector", 32'(sector),     32'd0);
        chk("glitch_fault",  32'(hall_fault), 32'd0);
        chk("glitch_noedge", 32'(sb.size()),  32'd0);

        // Invalid code, resync, clear, then a skip.
        step(3'b111, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'b100, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_clear("clear_after_invalid");
        step(3'b110, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(3'b010, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(3'b100, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_clear("clear_after_skip");
        step(3'b101, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        // Fault event coincident with clear_fault: fault stays set.
        step(3'b111, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);

        // Build up a valid period, then stall.
        step(3'b011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b010, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b110, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        while (cyc < last_edge + 999) begin
            @(posedge clk);
            #1;
        end
        chk("stall_before",    32'(stalled),      32'd0);
        chk("stall_pv_before", 32'(period_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("stall_set",       32'(stalled),      32'd1);
        chk("stall_pv",        32'(period_valid), 32'd0);
        step(3'b100, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b101, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-operation.
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        last_edge = cyc;
        push_exp(3'd4, 1'b0, 1'b0, 1'b0);
        repeat (HOLD) @(posedge clk);
        #1;
        step(3'b001, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'b011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hall_decoder.md
Name: hall_decoder

Overview:
- Consumes the 3-bit Hall code from the Hall sensor front end: the physical sensors, or the Hall simulator output `simulated_hall`.
- Synchronizes and debounces the code, then maps it to a commutation sector (0-5).
- Infers rotation direction and measures the clock count between consecutive legal Hall transitions.
- Feeds the commutation/PWM stage and the speed loop.
- Flags invalid codes, illegal sector skips and stall.

Parameters:
SYNC_STAGES, 2, synchronizer flops on hall_in (min 2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized clocks required to accept a new code (min 1, 16-bit)
PERIOD_WIDTH, 32, width of the edge timer and period output
TIMEOUT_CYCLES, 32'd50_000_000, clocks without an accepted edge before stall is declared

Ports:
clk  input  1  global clock
reset_n  input  1  asynchronous reset, active LOW; one clock domain, all flops reset by it
hall_in  input  3  raw Hall code {A,B,C}, asynchronous to clk
clear_fault  input  1  single-cycle clear of sticky hall_fault
sector  output  3  accepted sector 0-5; 3'd7 = invalid/unknown
direction  output  1  0 forward, 1 reverse (last legal step)
hall_edge  output  1  one-clock pulse when a new code is accepted
period  output  PERIOD_WIDTH  clocks between last two accepted edges
period_valid  output  1  period is a legal same-direction measurement
stalled  output  1  no accepted edge for TIMEOUT_CYCLES clocks
hall_fault  output  1  sticky: invalid code (000/111) or sector skip seen

Behaviour:
- Reset values:
  - Synchronizer and accepted code = 3'b000.
  - sector = 7; direction = 0; hall_edge = 0; period = 0.
  - period_valid = 0; stalled = 0; hall_fault = 0.
  - Edge timer = 0; debounce counter = 0.
  - The reset value of the accepted code does not raise a fault.
- Sector map:
  - 011→0, 010→1, 110→2, 100→3, 101→4, 001→5.
  - 000 and 111 map to 7.
- Debounce:
  - Counter clears whenever the synchronizer output changes, or equals the accepted code.
  - Otherwise it increments each clock.
  - On the DEBOUNCE_CYCLES-th consecutive clock of a stable new value, the code is accepted.
  - All outputs update on that edge and hall_edge = 1 for exactly one clock.
  - Total latency, from the first clk edge sampling the new hall_in to hall_edge high: SYNC_STAGES + DEBOUNCE_CYCLES clocks.
  - Glitches shorter than DEBOUNCE_CYCLES produce no edge.
- Step classification on accept (previous sector p, new sector n):
  - n = (p+1) mod 6: forward step, direction = 0.
  - n = (p+5) mod 6: reverse step, direction = 1.
  - n = 7: invalid; hall_fault set; period_valid cleared; direction held.
  - p = 7, n valid: resync; no direction change; period_valid = 0; no fault.
  - Any other n (skip of 2 or 3): hall_fault set; direction held; period_valid cleared.
- Edge timer:
  - Increments every clock and saturates at 2^PERIOD_WIDTH-1.
  - On accept: period <= timer+1 (saturating), timer <= 0.
  - Accepts spaced N clocks apart therefore give period = N.
- period_valid:
  - Set on a legal step whose direction equals that of the previous accepted legal step, with no stall in between.
  - Cleared on: reversal, fault, resync, stall, reset.
  - Consequence: first valid period appears on the 3rd consecutive same-direction edge after reset.
- Stall:
  - When timer reaches TIMEOUT_CYCLES: stalled = 1 and period_valid = 0.
  - The next accept clears stalled, but period_valid stays 0 until a further legal step.
- hall_fault:
  - Cleared by clear_fault.
  - A fault event in the same cycle as clear_fault wins (fault stays 1).
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Operation resumes on the first clock after release.

Test Plan:
- Forward sequence 011,010,110,100,101,001 repeated, each held 100 clocks, DEBOUNCE_CYCLES=4 → sector 0..5 wrap; direction=0; hall_edge each step 6 clocks after input change; period=100; period_valid=1 from 3rd edge.
- Reverse mid-run (at sector 3 apply 110) → sector=2; direction=1; period_valid=0 on that edge; next reverse step at 100 clocks → period_valid=1, period=100.
- 3-clock glitch 011→010→011 with DEBOUNCE_CYCLES=4 → no hall_edge; sector stays 0; no fault.
- Apply 111 → sector=7, hall_fault=1. Then apply 100 → sector=3, no direction change. Pulse clear_fault → hall_fault=0. Skip 010→100 → hall_fault=1.
- TIMEOUT_CYCLES=1000, hold code → stalled=1 at 1000 clocks after last edge, period_valid=0. Next legal edge → stalled=0, period_valid=0; following edge → period_valid=1.
- Assert reset_n low mid-sequence for 1 clock → all outputs at reset values asynchronously. First accepted code after release → resync with no direction/fault.
